// File: rtl/seq_det_param_if.sv
// Bus bundle for seq_det_param: configuration, qualified serial data, and match outputs.
interface seq_det_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 16
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               x_valid;
  logic               x;
  logic               cnt_clr;
  logic               z;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, x_valid, x, cnt_clr,
    input  z, match_count
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, x_valid, x, cnt_clr,
    output z, match_count
  );
endinterface

// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector with overlap/non-overlap matching.
// Define SEQDET_COUNT_EN to build the saturating match counter and its clear input.
module seq_det_param #(
  parameter int                   MAX_LEN     = 8,
  parameter int                   LEN_W       = $clog2(MAX_LEN) + 1,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 'b001,
  parameter int                   DEF_LEN     = 3,
  parameter bit                   DEF_OVERLAP = 1'b1,
  parameter int                   CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  seq_det_param_if.slave    bus
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_z;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_cfg_len;
  logic               w_match;
  logic               w_hit;

  assign w_hist_next = {r_hist[MAX_LEN-2:0], bus.x};
  assign w_fill_next = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
  assign w_cfg_len   = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;

  // Only the low r_len history bits take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < r_len) w_mask[i] = 1'b1;
    end
  end

  assign w_match = (r_len != '0) && (w_fill_next >= r_len) &&
                   (((w_hist_next ^ r_pat) & w_mask) == '0);
  assign w_hit   = bus.x_valid && !bus.cfg_load && w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= DEF_PATTERN;
      r_len  <= LEN_W'(DEF_LEN);
      r_ovl  <= DEF_OVERLAP;
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else if (bus.cfg_load) begin
      r_pat  <= bus.cfg_pattern;
      r_len  <= w_cfg_len;
      r_ovl  <= bus.cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else if (bus.x_valid) begin
      r_z    <= w_match;
      r_hist <= w_hist_next;
      // Non-overlap restarts the fill so the next match needs len fresh bits.
      r_fill <= (w_match && !r_ovl) ? '0 : w_fill_next;
    end else begin
      r_z    <= 1'b0;
    end
  end

  assign bus.z = r_z;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= w_hit ? CNT_W'(1) : '0;
    end else if (w_hit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.match_count = r_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt    = bus.cnt_clr ^ w_hit;
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Randomised and directed check of seq_det_param against a queue-based behavioural model.
module tb_seq_det_param;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int CNT_W   = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef SEQDET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 1'b0;

  always #5 clk = ~clk;

  seq_det_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_det_param #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DEF_PATTERN(8'b001),
    .DEF_LEN(3), .DEF_OVERLAP(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Model: the accepted bits since the last restart, newest at the back.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  int                 m_q[$];
  bit                 m_hit;
  bit                 exp_z;
  int                 exp_cnt;

  always @(posedge clk) begin
    m_hit = 1'b0;
    if (rst) begin
      m_pat = 8'b001; m_len = 3; m_ovl = 1'b1; m_q = {};
      exp_z = 1'b0; exp_cnt = 0;
    end else begin
      if (bus.cfg_load) begin
        m_pat = bus.cfg_pattern;
        m_len = (int'(bus.cfg_len) > MAX_LEN) ? MAX_LEN : int'(bus.cfg_len);
        m_ovl = bus.cfg_overlap;
        m_q   = {};
      end else if (bus.x_valid) begin
        m_q.push_back(int'(bus.x));
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        if (m_len > 0 && m_q.size() >= m_len) begin
          m_hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_q[m_q.size()-1-k] != int'(m_pat[k])) m_hit = 1'b0;
        end
        if (m_hit && !m_ovl) m_q = {};
      end
      exp_z = m_hit;
      if (CNT_ON) begin
        if (bus.cnt_clr) exp_cnt = m_hit ? 1 : 0;
        else if (m_hit && exp_cnt < CMAX) exp_cnt = exp_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_z", int'(bus.z), int'(exp_z));
      chk("model_cnt", int'(bus.match_count), exp_cnt);
    end
  end

  task automatic drive(input bit r, input bit ld, input bit v, input bit b, input bit clr);
    @(negedge clk);
    rst = r; bus.cfg_load = ld; bus.x_valid = v; bus.x = b; bus.cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input bit b);
    drive(1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o,
                      input bit v = 1'b0, input bit b = 1'b0);
    @(negedge clk);
    bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = o;
    drive(1'b0, 1'b1, v, b, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit ovl_z[6];
    bit novl_z[6];
    bit stim[6];
    bit a5[8];
    ovl_z  = '{0, 0, 0, 1, 0, 1};
    novl_z = '{0, 0, 0, 1, 0, 0};
    stim   = '{1, 0, 1, 0, 1, 0};
    a5     = '{1, 0, 1, 0, 0, 1, 0, 1};

    rst = 1'b1; bus.cfg_load = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
    bus.cfg_overlap = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0; bus.cnt_clr = 1'b0;
    do_reset();
    chk_en = 1'b1;
    chk("reset_z", int'(bus.z), 0);
    chk("reset_cnt", int'(bus.match_count), 0);

    // Default pattern 001
    bit_in(0); bit_in(0);
    chk("def_pre_z", int'(bus.z), 0);
    bit_in(1);
    chk("def_z", int'(bus.z), 1);
    chk("def_cnt", int'(bus.match_count), CNT_ON ? 1 : 0);
    idle();
    chk("def_after_z", int'(bus.z), 0);

    load(8'b1010, 4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bit_in(stim[i]);
      chk("ovl_z", int'(bus.z), int'(ovl_z[i]));
    end
    chk("ovl_cnt", int'(bus.match_count), CNT_ON ? 3 : 0);

    load(8'b1010, 4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bit_in(stim[i]);
      chk("novl_z", int'(bus.z), int'(novl_z[i]));
    end

    // Gaps of three invalid cycles between bits
    load(8'b001, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bit_in(i == 2);
      if (i == 2) chk("gap_z", int'(bus.z), 1);
      for (int g = 0; g < 3; g++) begin
        idle();
        chk("gap_idle_z", int'(bus.z), 0);
      end
    end

    load(8'h00, 0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      bit_in(1'($urandom_range(0, 1)));
      chk("len0_z", int'(bus.z), 0);
    end

    load(8'hA5, 15, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bit_in(a5[i]);
      chk("len_clamp_z", int'(bus.z), (i == 7) ? 1 : 0);
    end

    // Bit presented with cfg_load must be dropped
    load(8'b001, 3, 1'b1, 1'b1, 1'b0);
    bit_in(0); bit_in(1);
    chk("load_drop_z", int'(bus.z), 0);
    bit_in(0); bit_in(0); bit_in(1);
    chk("load_after_z", int'(bus.z), 1);

    load(8'b1, 1, 1'b1);
    for (int i = 0; i < 10; i++) bit_in(1);
    chk("sat_cnt", int'(bus.match_count), CNT_ON ? CMAX : 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_hit_cnt", int'(bus.match_count), CNT_ON ? 1 : 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_cnt", int'(bus.match_count), 0);

    load(8'b001, 3, 1'b1);
    bit_in(0); bit_in(0);
    do_reset();
    bit_in(1);
    chk("rst_mid_z", int'(bus.z), 0);

    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (r < 25) begin
        logic [LEN_W-1:0] l;
        l = ($urandom_range(0, 4) == 0) ? LEN_W'($urandom_range(0, 15))
                                          : LEN_W'($urandom_range(1, 4));
        load(MAX_LEN'($urandom), l, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        drive(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 40) == 0));
      end
    end

    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial bit-pattern detector. Watches a qualified 1-bit input stream and pulses `z` for one cycle each time the last `len` accepted bits equal a runtime-programmable pattern of up to `MAX_LEN` bits. Overlapping or non-overlapping matching is selectable at runtime, and an optional saturating match counter can be compiled in. It sits between the serial front end and the frame/control logic, and replaces the fixed 3-bit "001" detector.

## Interface
- `MAX_LEN`, 8, maximum pattern length in bits (≥2).
- `LEN_W`, `$clog2(MAX_LEN)+1`, width of the length field.
- `DEF_PATTERN`, `'b001`, pattern loaded at reset (MAX_LEN bits, right-aligned).
- `DEF_LEN`, 3, length loaded at reset.
- `DEF_OVERLAP`, 1, overlap mode loaded at reset.
- `CNT_W`, 16, match counter width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_load`  in  1  latch `cfg_pattern`/`cfg_len`/`cfg_overlap` on this edge.
- `cfg_pattern`  in  MAX_LEN  pattern; bit `len-1` is the first bit received, bit 0 the last.
- `cfg_len`  in  LEN_W  pattern length.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `x_valid`  in  1  `x` is sampled only when high.
- `x`  in  1  serial data bit.
- `cnt_clr`  in  1  clear the match counter.
- `z`  out  1  registered match pulse.
- `match_count`  out  CNT_W  number of matches (see Configuration).

## Operation
- State registers: `pat`, `len`, `ovl`, `hist[MAX_LEN-1:0]` (`hist[0]` is the newest bit), `fill` (0..MAX_LEN, saturating), `z`, `match_count`.
- Reset values:
  - `pat=DEF_PATTERN`, `len=DEF_LEN`, `ovl=DEF_OVERLAP`.
  - `hist=0`, `fill=0`, `z=0`, `match_count=0`.
- `cfg_load` has priority over data:
  - Latches the config registers and clears `hist` and `fill`. `z` goes to 0 next cycle.
  - `x` is ignored on a load edge, even if `x_valid` is high.
  - `match_count` is not affected.
- Length handling:
  - A `cfg_len` greater than MAX_LEN is clamped to MAX_LEN when loaded.
  - `cfg_len=0` disables detection: `z` never asserts, but `hist` and `fill` still update.
- On an accepted bit (`x_valid` high, no load):
  - Next history: `h' = {hist[MAX_LEN-2:0], x}`; next fill: `f' = min(fill+1, MAX_LEN)`.
  - `match = (len!=0) && (f' >= len) && (h'[len-1:0] == pat[len-1:0])`.
  - `z <= match`.
  - `hist <= h'`.
  - `fill <= (match && !ovl) ? 0 : f'`.
- Non-overlap mode: after a match, the next match needs `len` fresh bits.
- Cycles with `x_valid` low: `z <= 0`; `hist` and `fill` hold.
- Counter: increments on each `z`-producing match and saturates at all-ones.
  - `cnt_clr` sets the counter to 0.
  - `cnt_clr` together with a match sets it to 1.
- `rst` mid-stream discards any partial match; the detector restarts with the default config.

## Timing
- `z` is registered: it is high during the single cycle after the edge that samples the final pattern bit. Latency from that bit is 1 cycle.
- Back-to-back overlapping matches give `z` high on consecutive cycles. There is no bubble.
- `match_count` updates on the same edge that sets `z`.
- A config load takes effect on the next accepted bit. The first possible match comes `len` accepted bits after the load edge.

## Configuration
- `SEQDET_COUNT_EN` defined: the saturating `match_count` register and `cnt_clr` are implemented.
- Not defined: no counter flops are generated, `match_count` is tied to 0, and `cnt_clr` is ignored.
- `z` behaviour is identical in both builds.

## Test plan
- Reset defaults: stream 0,0,1 with `x_valid=1` → `z=1` for exactly one cycle after the "1" edge; `match_count=1` (with the macro).
- Overlap: load pattern `'b1010`, len 4, overlap=1; stream 1,0,1,0,1,0 → `z` pulses after bit 4 and after bit 6; count 2.
- Non-overlap: same pattern with overlap=0 and the same stream → single `z` after bit 4; count 1.
- Gaps: the default pattern with `x_valid` low for 3 cycles between each bit → `z` still pulses once, after the last valid bit, and is 0 during every gap cycle.
- Config edges:
  - `cfg_len=0` → `z` stays 0 for 50 random bits.
  - `cfg_len=15` with MAX_LEN=8 → behaves as len 8; the pattern `'hA5` matches after 8 bits.
  - `cfg_load` asserted with `x_valid=1` → that bit is ignored.
- Counter: with CNT_W=2, 5 matches → count saturates at 3. `cnt_clr` on a match edge → count 1. `rst` mid-pattern → no `z` on the remaining bits.
